// File: rtl/macc_pkg.sv
// Shared types and helpers for the shared-MACC scheduler.
// Pure definitions: no latency and no backpressure of their own.
package macc_pkg;

   localparam int A_W   = 25;
   localparam int B_W   = 18;
   localparam int P_W   = 48;
   localparam int M_W   = A_W + B_W;
   localparam int MAX_N = 8;
   localparam int ID_W  = 3;

   typedef struct packed {
      logic [A_W-1:0]  a;
      logic [B_W-1:0]  b;
      logic            c;
      logic            acc;
      logic [ID_W-1:0] id;
   } macc_op_t;

   // Returns {found, index} of the first set mask bit after ptr, wrapping modulo n.
   function automatic logic [ID_W:0] rr_next(input logic [ID_W-1:0]  ptr,
                                             input logic [MAX_N-1:0] mask,
                                             input int               n);
      logic            found;
      logic [ID_W-1:0] idx;
      int              j;
      found = 1'b0;
      idx   = '0;
      for (int i = 1; i <= MAX_N; i++) begin
         j = (int'(ptr) + i) % n;
         if (i <= n && !found && mask[ID_W'(j)]) begin
            found = 1'b1;
            idx   = ID_W'(j);
         end
      end
      return {found, idx};
   endfunction

endpackage

// File: rtl/macc_pipe.sv
// Shared multiply-accumulate datapath: operand reg, multiply reg, combinational add.
// LAT-1 register stages here; the caller registers the sum as the LAT-th stage.
// No backpressure: one op may enter every cycle and always drains.
module macc_pipe
   import macc_pkg::*;
#(
   parameter int LAT = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_vld,
   input  macc_op_t        in_op,
   input  logic [P_W-1:0]  acc_in,
   output logic            out_vld,
   output logic [ID_W-1:0] out_id,
   output logic [P_W-1:0]  out_p
);

   localparam int S = LAT - 1;

   logic [S-1:0]   vld_q;
   macc_op_t       op_q [S];
   logic [M_W-1:0] prod_fin;

   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= in_vld;
         for (int k = 1; k < S; k++) begin
            vld_q[k] <= vld_q[k-1];
         end
      end
   end

   // Payload needs no reset: nothing downstream looks at it without a valid bit.
   always_ff @(posedge clk) begin
      op_q[0] <= in_op;
      for (int k = 1; k < S; k++) begin
         op_q[k] <= op_q[k-1];
      end
   end

   generate
      if (S == 1) begin : g_comb_mul
         assign prod_fin = M_W'(op_q[0].a) * M_W'(op_q[0].b);
      end else begin : g_reg_mul
         logic [M_W-1:0] prod_q [1:S-1];
         always_ff @(posedge clk) begin
            prod_q[1] <= M_W'(op_q[0].a) * M_W'(op_q[0].b);
            for (int k = 2; k < S; k++) begin
               prod_q[k] <= prod_q[k-1];
            end
         end
         assign prod_fin = prod_q[S-1];
      end
   endgenerate

   // The accumulator is sampled here, at the last stage, so it always holds the previous result.
   assign out_vld = vld_q[S-1];
   assign out_id  = op_q[S-1].id;
   assign out_p   = P_W'(prod_fin) + P_W'(op_q[S-1].c) + (op_q[S-1].acc ? acc_in : '0);

endmodule

// File: rtl/macc_arbiter.sv
// Round-robin sharing of one MACC pipe between N requesters, each with a private accumulator.
// Issue-to-result latency LAT cycles; one outstanding op per requester.
// Backpressure via req_ready only; responses cannot be stalled.
module macc_arbiter
   import macc_pkg::*;
#(
   parameter  int N     = 4,
   parameter  int LAT   = 3,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req_valid,
   output logic [N-1:0]     req_ready,
   input  logic [N*A_W-1:0] req_a,
   input  logic [N*B_W-1:0] req_b,
   input  logic [N-1:0]     req_c,
   input  logic [N-1:0]     req_acc,
   output logic             rsp_valid,
   output logic [IDX_W-1:0] rsp_id,
   output logic [P_W-1:0]   rsp_p,
   output logic             busy
);

   logic [N-1:0]     inflight_q;
   logic [N-1:0]     inflight_d;
   logic [N-1:0]     elig;
   logic [N-1:0]     clr_vec;
   logic [IDX_W-1:0] last_q;
   logic [P_W-1:0]   acc_q [N];

   logic [ID_W:0]    rr;
   logic             gnt_found;
   logic [ID_W-1:0]  gnt_idx;
   macc_op_t         issue_op;
   logic             issue_vld;

   logic             pipe_vld;
   logic [ID_W-1:0]  pipe_id;
   logic [P_W-1:0]   pipe_p;
   logic [P_W-1:0]   acc_rd;

   always_comb begin
      req_ready  = '0;
      issue_op   = '0;
      acc_rd     = '0;
      clr_vec    = '0;
      elig       = req_valid & ~inflight_q;
      rr         = rr_next(ID_W'(last_q), MAX_N'(elig), N);
      gnt_found  = rr[ID_W];
      gnt_idx    = rr[ID_W-1:0];
      for (int i = 0; i < N; i++) begin
         if (rst && gnt_found && gnt_idx == ID_W'(i)) begin
            req_ready[i] = 1'b1;
            issue_op.a   = req_a[i*A_W +: A_W];
            issue_op.b   = req_b[i*B_W +: B_W];
            issue_op.c   = req_c[i];
            issue_op.acc = req_acc[i];
            issue_op.id  = ID_W'(i);
         end
         if (pipe_id == ID_W'(i)) begin
            acc_rd = acc_q[i];
         end
         if (rsp_valid && rsp_id == IDX_W'(i)) begin
            clr_vec[i] = 1'b1;
         end
      end
      // A ready only ever goes to a valid requester, so ready alone marks the handshake.
      issue_vld  = |req_ready;
      inflight_d = (inflight_q | req_ready) & ~clr_vec;
   end

   macc_pipe #(
      .LAT (LAT)
   ) u_pipe (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (issue_vld),
      .in_op   (issue_op),
      .acc_in  (acc_rd),
      .out_vld (pipe_vld),
      .out_id  (pipe_id),
      .out_p   (pipe_p)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         inflight_q <= '0;
         busy       <= 1'b0;
         last_q     <= IDX_W'(N - 1);
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_p      <= '0;
         for (int i = 0; i < N; i++) begin
            acc_q[i] <= '0;
         end
      end else begin
         inflight_q <= inflight_d;
         busy       <= |inflight_d;
         rsp_valid  <= pipe_vld;
         if (issue_vld) begin
            last_q <= gnt_idx[IDX_W-1:0];
         end
         // Result and accumulator land on the same edge.
         if (pipe_vld) begin
            rsp_id <= pipe_id[IDX_W-1:0];
            rsp_p  <= pipe_p;
            for (int i = 0; i < N; i++) begin
               if (pipe_id == ID_W'(i)) begin
                  acc_q[i] <= pipe_p;
               end
            end
         end
      end
   end

endmodule
